load_store_unit: RTL and testbench

Memory-stage sequencer between the execute stage and `memory_interface`. It accepts one load or store per handshake and translates RV32 funct3 into a byte, half or word request. It holds the request stable for the memory latency, then sign- or zero-extends load data. It returns one completion, a result or a fault, to writeback.

---
 rtl/load_store_unit_pkg.sv | 63 ++++++
 rtl/load_store_unit_extend.sv | 23 ++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants, op struct and funct3 decode helpers for the load/store unit.
// Optional feature macro: LSU_ALIGN_CHECK_EN (see load_store_unit.sv).
package load_store_unit_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 2;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE       = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 2'd3;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_ST_IDLE   = 2'd0,
    LSU_ST_ACCESS = 2'd1,
    LSU_ST_RESP   = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [2:0] funct3;
    logic       store;
    logic [4:0] rd;
  } lsu_op_t;

  // Unsigned loads have no store counterpart.
  function automatic logic f3_legal(input logic [2:0] f3, input logic store);
    case (f3)
      LSU_F3_B, LSU_F3_H, LSU_F3_W: f3_legal = 1'b1;
      LSU_F3_BU, LSU_F3_HU:         f3_legal = !store;
      default:                      f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [MEM_COUNT_W-1:0] f3_count(input logic [1:0] sz);
    case (sz)
      2'b00:   f3_count = MEM_COUNT_BYTE;
      2'b01:   f3_count = MEM_COUNT_HALF;
      default: f3_count = MEM_COUNT_WORD;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   f3_misaligned = 1'b0;
      2'b01:   f3_misaligned = a[0];
      default: f3_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Combinational load-data extension: masks right-justified memory data to
// byte/half/word and sign- or zero-extends according to funct3.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [WORD_W-1:0] rd_data_i,
  input  logic [2:0]        funct3_i,
  output logic [WORD_W-1:0] data_o
);

  logic sx;
  assign sx = ~funct3_i[2];

  always_comb begin
    data_o = rd_data_i;
    case (funct3_i[1:0])
      2'b00:   data_o = {{(WORD_W-8){sx & rd_data_i[7]}},   rd_data_i[7:0]};
      2'b01:   data_o = {{(WORD_W-16){sx & rd_data_i[15]}}, rd_data_i[15:0]};
      default: data_o = rd_data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage sequencer: one load/store in flight, fixed memory latency,
// single completion (result or fault) to writeback.
// Optional: define LSU_ALIGN_CHECK_EN to fault misaligned ops at accept.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_ex_valid,
  output logic                   o_ex_ready,
  input  logic [ADDR_W-1:0]      i_ex_addr,
  input  logic [WORD_W-1:0]      i_ex_wr_data,
  input  logic [2:0]             i_ex_funct3,
  input  logic                   i_ex_store,
  input  logic [4:0]             i_ex_rd,
  output logic [ADDR_W-1:0]      o_mem_req_addr,
  output logic [WORD_W-1:0]      o_mem_req_wr_data,
  output logic [MEM_COUNT_W-1:0] o_mem_req_count,
  output logic                   o_mem_req_wr_en,
  input  logic [WORD_W-1:0]      i_mem_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_mem_res_code,
  output logic                   o_wb_valid,
  input  logic                   i_wb_ready,
  output logic [WORD_W-1:0]      o_wb_data,
  output logic [4:0]             o_wb_rd,
  output logic                   o_wb_fault
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  lsu_state_e               state_q;
  lsu_op_t                  op_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [ADDR_W-1:0]        req_addr_q;
  logic [WORD_W-1:0]        req_wr_data_q;
  logic [MEM_COUNT_W-1:0]   req_count_q;
  logic                     req_wr_en_q;
  logic [WORD_W-1:0]        wb_data_q;
  logic [4:0]               wb_rd_q;
  logic                     wb_fault_q;

  logic                     accept_fault;
  logic [WORD_W-1:0]        ext_data;
  logic [MEM_CODE_W-1:0]    exp_code;

  always_comb begin
    accept_fault = !f3_legal(i_ex_funct3, i_ex_store);
`ifdef LSU_ALIGN_CHECK_EN
    accept_fault = accept_fault || f3_misaligned(i_ex_funct3[1:0], i_ex_addr[1:0]);
`endif
  end

  assign exp_code = op_q.store ? MEM_CODE_WRITE : MEM_CODE_READ;

  load_extend u_extend (
    .rd_data_i (i_mem_res_rd_data),
    .funct3_i  (op_q.funct3),
    .data_o    (ext_data)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= LSU_ST_IDLE;
      op_q          <= '0;
      cnt_q         <= '0;
      req_addr_q    <= '0;
      req_wr_data_q <= '0;
      req_count_q   <= MEM_COUNT_NONE;
      req_wr_en_q   <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_fault_q    <= 1'b0;
    end else begin
      case (state_q)
        LSU_ST_IDLE: begin
          if (i_ex_valid) begin
            op_q <= '{funct3: i_ex_funct3, store: i_ex_store, rd: i_ex_rd};
            if (accept_fault) begin
              state_q    <= LSU_ST_RESP;
              wb_fault_q <= 1'b1;
              wb_data_q  <= '0;
              wb_rd_q    <= '0;
            end else begin
              state_q       <= LSU_ST_ACCESS;
              cnt_q         <= i_ex_store ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
              req_addr_q    <= i_ex_addr;
              req_wr_data_q <= i_ex_store ? i_ex_wr_data : '0;
              req_count_q   <= f3_count(i_ex_funct3[1:0]);
              req_wr_en_q   <= i_ex_store;
            end
          end
        end
        LSU_ST_ACCESS: begin
          if (cnt_q == '0) begin
            // Response is sampled on the same edge the request is released.
            state_q       <= LSU_ST_RESP;
            req_addr_q    <= '0;
            req_wr_data_q <= '0;
            req_count_q   <= MEM_COUNT_NONE;
            req_wr_en_q   <= 1'b0;
            if (i_mem_res_code == exp_code) begin
              wb_fault_q <= 1'b0;
              wb_data_q  <= op_q.store ? '0 : ext_data;
              wb_rd_q    <= op_q.store ? 5'd0 : op_q.rd;
            end else begin
              wb_fault_q <= 1'b1;
              wb_data_q  <= '0;
              wb_rd_q    <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        LSU_ST_RESP: begin
          if (i_wb_ready) begin
            state_q    <= LSU_ST_IDLE;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_fault_q <= 1'b0;
          end
        end
        default: state_q <= LSU_ST_IDLE;
      endcase
    end
  end

  assign o_ex_ready        = (state_q == LSU_ST_IDLE);
  assign o_wb_valid        = (state_q == LSU_ST_RESP);
  assign o_wb_data         = wb_data_q;
  assign o_wb_rd           = wb_rd_q;
  assign o_wb_fault        = wb_fault_q;
  assign o_mem_req_addr    = req_addr_q;
  assign o_mem_req_wr_data = req_wr_data_q;
  assign o_mem_req_count   = req_count_q;
  assign o_mem_req_wr_en   = req_wr_en_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory model plus an
// independent reference that derives results from address/size/extension rules.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int RL = 2;
  localparam int WL = 1;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic                   clk, aresetn;
  logic                   i_ex_valid, o_ex_ready;
  logic [ADDR_W-1:0]      i_ex_addr;
  logic [WORD_W-1:0]      i_ex_wr_data;
  logic [2:0]             i_ex_funct3;
  logic                   i_ex_store;
  logic [4:0]             i_ex_rd;
  logic [ADDR_W-1:0]      o_mem_req_addr;
  logic [WORD_W-1:0]      o_mem_req_wr_data;
  logic [MEM_COUNT_W-1:0] o_mem_req_count;
  logic                   o_mem_req_wr_en;
  logic [WORD_W-1:0]      i_mem_res_rd_data;
  logic [MEM_CODE_W-1:0]  i_mem_res_code;
  logic                   o_wb_valid, i_wb_ready;
  logic [WORD_W-1:0]      o_wb_data;
  logic [4:0]             o_wb_rd;
  logic                   o_wb_fault;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_data;
  logic        last_fault;
  logic [4:0]  last_rd;

  load_store_unit #(.READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .clk(clk), .aresetn(aresetn),
    .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready),
    .i_ex_addr(i_ex_addr), .i_ex_wr_data(i_ex_wr_data), .i_ex_funct3(i_ex_funct3),
    .i_ex_store(i_ex_store), .i_ex_rd(i_ex_rd),
    .o_mem_req_addr(o_mem_req_addr), .o_mem_req_wr_data(o_mem_req_wr_data),
    .o_mem_req_count(o_mem_req_count), .o_mem_req_wr_en(o_mem_req_wr_en),
    .i_mem_res_rd_data(i_mem_res_rd_data), .i_mem_res_code(i_mem_res_code),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
    .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_wb_fault(o_wb_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory environment ----------------
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       pl_en;
  logic [7:0] pl_a, pl_d;

  function automatic int env_size(input logic [MEM_COUNT_W-1:0] c);
    if (c == MEM_COUNT_BYTE) return 1;
    if (c == MEM_COUNT_HALF) return 2;
    return 4;
  endfunction

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (o_mem_req_count != MEM_COUNT_NONE && o_mem_req_wr_en &&
             (int'(o_mem_req_addr[7:0]) % env_size(o_mem_req_count)) == 0)
      for (int i = 0; i < env_size(o_mem_req_count); i++)
        mem[(int'(o_mem_req_addr[7:0]) + i) & 255] <= o_mem_req_wr_data[8*i +: 8];
  end

  always @* begin
    i_mem_res_code    = MEM_CODE_NONE;
    i_mem_res_rd_data = '0;
    if (o_mem_req_count != MEM_COUNT_NONE) begin
      if ((int'(o_mem_req_addr[7:0]) % env_size(o_mem_req_count)) != 0)
        i_mem_res_code = MEM_CODE_MISALIGNED;
      else if (o_mem_req_wr_en)
        i_mem_res_code = MEM_CODE_WRITE;
      else begin
        i_mem_res_code = MEM_CODE_READ;
        for (int i = 0; i < env_size(o_mem_req_count); i++)
          i_mem_res_rd_data[8*i +: 8] = mem[(int'(o_mem_req_addr[7:0]) + i) & 255];
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic ref_model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           output logic ef, output logic [31:0] ed, output logic [4:0] erd,
                           output int elat, output logic issue, output int size);
    bit legal, mis;
    longint v;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis   = (addr % size) != 0;
    issue = legal && !(ALIGN && mis);
    ef = 1'b1; ed = '0; erd = '0; elat = 0;
    if (issue) begin
      elat = st ? WL : RL;
      if (!mis) begin
        ef = 1'b0;
        if (st) begin
          for (int i = 0; i < size; i++) ref_mem[(addr + i) & 255] = wd[8*i +: 8];
        end else begin
          v = 0;
          for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[(addr + i) & 255]) << (8*i));
          if (!f3[2] && v >= (longint'(1) << (8*size - 1))) v = v - (longint'(1) << (8*size));
          ed  = v[31:0];
          erd = rd;
        end
      end
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // One full operation: offer, watch ACCESS, check completion, optional backpressure.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input int hold,
                       input string tag);
    logic ef, issue;
    logic [31:0] ed;
    logic [4:0] erd;
    int elat, n, size;
    ref_model(st, f3, addr, wd, rd, ef, ed, erd, elat, issue, size);
    @(negedge clk);
    checks++;
    if (o_ex_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_before: got %b want 1", tag, o_ex_ready);
    end
    i_ex_valid = 1'b1; i_ex_store = st; i_ex_funct3 = f3;
    i_ex_addr = addr; i_ex_wr_data = wd; i_ex_rd = rd;
    @(posedge clk);
    #1 i_ex_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (o_wb_valid !== 1'b1 && n < 20) begin
      checks++;
      if (o_mem_req_count !== f3_count(f3[1:0]) || o_mem_req_addr !== addr ||
          o_mem_req_wr_en !== st || (st && o_mem_req_wr_data !== wd) || o_ex_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s access_req: got cnt=%0d addr=%h we=%b wd=%h rdy=%b want cnt=%0d addr=%h we=%b wd=%h rdy=0",
                 tag, o_mem_req_count, o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_data, o_ex_ready,
                 f3_count(f3[1:0]), addr, st, wd);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != elat) begin
      failures++; $display("FAIL %s latency: got %0d edges after accept want %0d", tag, n, elat);
    end
    last_data = o_wb_data; last_fault = o_wb_fault; last_rd = o_wb_rd;
    checks++;
    if (o_wb_data !== ed || o_wb_fault !== ef || o_wb_rd !== erd) begin
      failures++;
      $display("FAIL %s payload: got data=%h fault=%b rd=%0d want data=%h fault=%b rd=%0d",
               tag, o_wb_data, o_wb_fault, o_wb_rd, ed, ef, erd);
    end
    checks++;
    if (o_mem_req_count !== MEM_COUNT_NONE || o_mem_req_wr_en !== 1'b0 || o_ex_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s resp_idle_req: got cnt=%0d we=%b rdy=%b want cnt=0 we=0 rdy=0",
               tag, o_mem_req_count, o_mem_req_wr_en, o_ex_ready);
    end
    // While stalled, keep offering a store that must not be issued.
    for (int h = 0; h < hold; h++) begin
      i_ex_valid = 1'b1; i_ex_store = 1'b1; i_ex_funct3 = 3'd2; i_ex_addr = 32'h40;
      @(negedge clk);
      checks++;
      if (o_wb_valid !== 1'b1 || o_wb_data !== ed || o_wb_fault !== ef || o_wb_rd !== erd ||
          o_ex_ready !== 1'b0 || o_mem_req_count !== MEM_COUNT_NONE) begin
        failures++;
        $display("FAIL %s hold%0d: got v=%b data=%h fault=%b rd=%0d rdy=%b cnt=%0d want v=1 data=%h fault=%b rd=%0d rdy=0 cnt=0",
                 tag, h, o_wb_valid, o_wb_data, o_wb_fault, o_wb_rd, o_ex_ready, o_mem_req_count, ed, ef, erd);
      end
    end
    i_ex_valid = 1'b0;
    i_wb_ready = 1'b1;
    @(posedge clk);
    #1 i_wb_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (o_wb_valid !== 1'b0 || o_ex_ready !== 1'b1) begin
      failures++; $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", tag, o_wb_valid, o_ex_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    #12;
    checks++;
    if (o_ex_ready !== 1'b1 || o_wb_valid !== 1'b0 || o_wb_data !== '0 || o_wb_rd !== '0 ||
        o_wb_fault !== 1'b0 || o_mem_req_count !== MEM_COUNT_NONE || o_mem_req_addr !== '0 ||
        o_mem_req_wr_data !== '0 || o_mem_req_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b v=%b data=%h rd=%0d f=%b cnt=%0d addr=%h we=%b want rdy=1 v=0 rest 0",
               o_ex_ready, o_wb_valid, o_wb_data, o_wb_rd, o_wb_fault, o_mem_req_count, o_mem_req_addr, o_mem_req_wr_en);
    end
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic test_directed();
    preload(8'h10, 8'hF0); preload(8'h11, 8'h00); preload(8'h12, 8'h00); preload(8'h13, 8'h00);
    do_op(1'b0, LSU_F3_B, 32'h10, 32'h0, 5'd3, 0, "lb");
    checks++;
    if (last_data !== 32'hFFFF_FFF0) begin
      failures++; $display("FAIL lb_const: got %h want FFFFFFF0", last_data);
    end
    do_op(1'b0, LSU_F3_BU, 32'h10, 32'h0, 5'd4, 0, "lbu");
    checks++;
    if (last_data !== 32'h0000_00F0) begin
      failures++; $display("FAIL lbu_const: got %h want 000000F0", last_data);
    end
    do_op(1'b1, LSU_F3_W, 32'h20, 32'hDEAD_BEEF, 5'd9, 0, "sw");
    do_op(1'b0, LSU_F3_W, 32'h20, 32'h0, 5'd7, 0, "lw");
    checks++;
    if (last_data !== 32'hDEAD_BEEF || last_rd !== 5'd7) begin
      failures++; $display("FAIL lw_const: got %h rd=%0d want DEADBEEF rd=7", last_data, last_rd);
    end
    do_op(1'b1, LSU_F3_H, 32'h22, 32'h1234_8001, 5'd1, 0, "sh");
    do_op(1'b0, LSU_F3_H, 32'h22, 32'h0, 5'd5, 0, "lh");
    checks++;
    if (last_data !== 32'hFFFF_8001) begin
      failures++; $display("FAIL lh_const: got %h want FFFF8001", last_data);
    end
    do_op(1'b0, LSU_F3_HU, 32'h22, 32'h0, 5'd6, 0, "lhu");
    checks++;
    if (last_data !== 32'h0000_8001) begin
      failures++; $display("FAIL lhu_const: got %h want 00008001", last_data);
    end
    do_op(1'b0, LSU_F3_W, 32'h21, 32'h0, 5'd8, 0, "lw_misaligned");
    checks++;
    if (last_fault !== 1'b1 || last_data !== '0) begin
      failures++; $display("FAIL lw_mis_const: got fault=%b data=%h want fault=1 data=0", last_fault, last_data);
    end
    do_op(1'b0, 3'b011, 32'h20, 32'h0, 5'd2, 0, "illegal_f3");
    do_op(1'b1, LSU_F3_BU, 32'h20, 32'h55, 5'd2, 0, "illegal_store_u");
    do_op(1'b0, LSU_F3_W, 32'h20, 32'h0, 5'd7, 0, "lw_after_illegal");
  endtask

  task automatic test_backpressure();
    do_op(1'b0, LSU_F3_W, 32'h20, 32'h0, 5'd11, 5, "bp_load");
    do_op(1'b1, LSU_F3_B, 32'h30, 32'hA5, 5'd12, 5, "bp_store");
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a;
    int sz;
    for (int k = 0; k < 60; k++) begin
      f3 = 3'($urandom_range(0, 7));
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 32'd1);
      do_op(1'($urandom_range(0, 1)), f3, a, $urandom, 5'($urandom_range(1, 31)),
            $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int cyc;
    i_ex_store = 1'b0; i_ex_funct3 = LSU_F3_W; i_ex_addr = 32'h20; i_ex_rd = 5'd1;
    i_wb_ready = 1'b1;
    @(negedge clk);
    i_ex_valid = 1'b1;
    cyc = 0;
    while (acc_cyc.size() < 3 && cyc < 40) begin
      if (o_ex_ready === 1'b1) acc_cyc.push_back(cyc);
      if (acc_cyc.size() < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(posedge clk);
    #1 i_ex_valid = 1'b0;
    checks++;
    if (acc_cyc.size() != 3) begin
      failures++; $display("FAIL b2b_accepts: got %0d accepts want 3", acc_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != RL + 2) begin
          failures++; $display("FAIL b2b_gap%0d: got %0d cycles want %0d", i, acc_cyc[i] - acc_cyc[i-1], RL + 2);
        end
      end
    end
    cyc = 0;
    while (o_ex_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    i_wb_ready = 1'b0;
    checks++;
    if (o_ex_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_drain: got rdy=%b want 1", o_ex_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_ex_valid = 1'b1; i_ex_store = 1'b0; i_ex_funct3 = LSU_F3_W; i_ex_addr = 32'h24; i_ex_rd = 5'd9;
    @(posedge clk);
    #1 i_ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_mem_req_count !== MEM_COUNT_WORD) begin
      failures++; $display("FAIL rst_mid_access: got cnt=%0d want %0d", o_mem_req_count, MEM_COUNT_WORD);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (o_mem_req_count !== MEM_COUNT_NONE || o_ex_ready !== 1'b1 || o_wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: got cnt=%0d rdy=%b v=%b want cnt=0 rdy=1 v=0", o_mem_req_count, o_ex_ready, o_wb_valid);
    end
    @(negedge clk);
    aresetn = 1'b1;
    repeat (RL + 2) @(negedge clk);
    checks++;
    if (o_wb_valid !== 1'b0 || o_ex_ready !== 1'b1 || o_mem_req_count !== MEM_COUNT_NONE) begin
      failures++;
      $display("FAIL rst_mid_after: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0", o_wb_valid, o_ex_ready, o_mem_req_count);
    end
  endtask

  initial begin
    i_ex_valid = 1'b0; i_ex_addr = '0; i_ex_wr_data = '0; i_ex_funct3 = '0;
    i_ex_store = 1'b0; i_ex_rd = '0; i_wb_ready = 1'b0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    test_reset();
    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
    test_directed();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
